// File: rtl/iq_frame_pkg.sv
// Shared types and helpers for the IQ frame dispatcher.
package iq_frame_pkg;

    localparam int unsigned IQ_SAMPLE_W = 16;
    localparam int unsigned PTR_MAX_W   = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    typedef struct packed {
        logic [IQ_SAMPLE_W-1:0] i;
        logic [IQ_SAMPLE_W-1:0] q;
    } iq_sample_t;

    // Distance wr - rd, kept to the low w bits so pointer wrap is transparent.
    function automatic logic [PTR_MAX_W-1:0] ptr_dist(input logic [PTR_MAX_W-1:0] wr,
                                                      input logic [PTR_MAX_W-1:0] rd,
                                                      input int unsigned          w);
        logic [PTR_MAX_W-1:0] mask;
        mask = (PTR_MAX_W'(1) << w) - PTR_MAX_W'(1);
        return (wr - rd) & mask;
    endfunction

endpackage

// File: rtl/iq_frame_if.sv
// Sample stream in, frame beats out, classifier result strobe back.
interface iq_frame_if #(
    parameter int unsigned SAMPLE_W = 16
) ();
    logic                in_valid;
    logic [SAMPLE_W-1:0] in_i;
    logic [SAMPLE_W-1:0] in_q;
    logic                in_ready;
    logic                out_valid;
    logic [SAMPLE_W-1:0] out_i;
    logic [SAMPLE_W-1:0] out_q;
    logic                out_last;
    logic                res_vld;

    modport master (
        output in_valid, in_i, in_q, res_vld,
        input  in_ready, out_valid, out_i, out_q, out_last
    );

    modport slave (
        input  in_valid, in_i, in_q, res_vld,
        output in_ready, out_valid, out_i, out_q, out_last
    );
endinterface

// File: rtl/iq_frame_ram.sv
// Simple dual-port sample buffer: one write port, one registered read port.
module iq_frame_ram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 32,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    // Output register carries a reset so the frame bus idles at zero.
    always_ff @(posedge clk) begin
        if (rst)     rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/iq_frame_dispatcher.sv
// Buffers an IQ stream and dispatches fixed-length frames, waiting for a result between frames.
// Optional IQ_FRAME_OVERLAP_EN: each frame releases HOP samples instead of FRAME_LEN.
module iq_frame_dispatcher
    import iq_frame_pkg::*;
#(
    parameter int unsigned SAMPLE_W    = 16,
    parameter int unsigned FRAME_LEN   = 128,
    parameter int unsigned DEPTH       = 32768,
    parameter int unsigned HOP         = 64,
    parameter int unsigned TIMEOUT_CYC = 1000000,
    parameter int unsigned AW          = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    iq_frame_if.slave     io,
    output logic          busy,
    output logic          overflow,
    output logic          timeout,
    output logic [15:0]   frame_cnt,
    output logic [AW:0]   level
);
    localparam int unsigned PW     = AW + 1;
    localparam int unsigned DW     = 2 * SAMPLE_W;
    localparam int unsigned IDX_W  = $clog2(FRAME_LEN);
    localparam int unsigned WCNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef IQ_FRAME_OVERLAP_EN
    localparam int unsigned REL    = HOP;
`else
    // HOP is inert when frames are disjoint.
    localparam int unsigned REL    = FRAME_LEN + 0 * HOP;
`endif

    state_e              state_q, state_nxt;
    logic [PW-1:0]       wr_ptr, rd_ptr, wr_nxt, rd_nxt, level_nxt;
    logic [IDX_W-1:0]    rd_idx, idx_nxt;
    logic [WCNT_W-1:0]   wait_cnt, wcnt_nxt;
    logic                wr_fire_c, rd_en_c, release_c, timeout_nxt, last_nxt;
    logic [AW-1:0]       rd_addr_c;
    logic [DW-1:0]       ram_rdata;

    assign wr_fire_c = io.in_valid & io.in_ready;
    assign rd_addr_c = rd_ptr[AW-1:0] + AW'(rd_idx);
    assign wr_nxt    = wr_ptr + PW'(wr_fire_c);
    assign rd_nxt    = rd_ptr + (release_c ? PW'(REL) : '0);
    assign level_nxt = PW'(ptr_dist(PTR_MAX_W'(wr_nxt), PTR_MAX_W'(rd_nxt), PW));

    iq_frame_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire_c),
        .waddr (wr_ptr[AW-1:0]),
        .wdata ({io.in_i, io.in_q}),
        .re    (rd_en_c),
        .raddr (rd_addr_c),
        .rdata (ram_rdata)
    );

    assign io.out_i = ram_rdata[DW-1:SAMPLE_W];
    assign io.out_q = ram_rdata[SAMPLE_W-1:0];

    // Next-state and per-cycle strobes.
    always_comb begin
        state_nxt   = state_q;
        idx_nxt     = rd_idx;
        wcnt_nxt    = wait_cnt;
        rd_en_c     = 1'b0;
        release_c   = 1'b0;
        timeout_nxt = 1'b0;
        last_nxt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (en && (level >= PW'(FRAME_LEN))) begin
                    state_nxt = SEND;
                    idx_nxt   = '0;
                end
            end
            SEND: begin
                rd_en_c = 1'b1;
                idx_nxt = rd_idx + IDX_W'(1);
                if (rd_idx == IDX_W'(FRAME_LEN - 1)) begin
                    state_nxt = WAIT;
                    last_nxt  = 1'b1;
                    wcnt_nxt  = '0;
                end
            end
            WAIT: begin
                wcnt_nxt = wait_cnt + WCNT_W'(1);
                // A result arriving on the final wait cycle suppresses the timeout.
                if (io.res_vld) begin
                    state_nxt = IDLE;
                    release_c = 1'b1;
                end else if (wait_cnt == WCNT_W'(TIMEOUT_CYC - 1)) begin
                    state_nxt   = IDLE;
                    release_c   = 1'b1;
                    timeout_nxt = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, pointers and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rd_idx       <= '0;
            wait_cnt     <= '0;
            level        <= '0;
            io.in_ready  <= 1'b1;
            io.out_valid <= 1'b0;
            io.out_last  <= 1'b0;
            busy         <= 1'b0;
            overflow     <= 1'b0;
            timeout      <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state_q      <= state_nxt;
            wr_ptr       <= wr_nxt;
            rd_ptr       <= rd_nxt;
            rd_idx       <= idx_nxt;
            wait_cnt     <= wcnt_nxt;
            level        <= level_nxt;
            io.in_ready  <= (level_nxt < PW'(DEPTH));
            io.out_valid <= rd_en_c;
            io.out_last  <= last_nxt;
            busy         <= (state_nxt != IDLE);
            overflow     <= overflow | (io.in_valid & ~io.in_ready);
            timeout      <= timeout_nxt;
            if (release_c) frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule
